// File: rtl/ysyx_23060332_ifu_if.sv
// Bundle of the IFU's instruction-memory, decode and redirect signals.
// The master modport is the IFU side; slave is the surrounding core and memory.
interface ysyx_23060332_ifu_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_addr;
  logic            inst_fault;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;
  logic [XLEN-1:0] pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_addr, inst_fault,
    input  inst_ready,
    input  jump_en, jump_addr,
    output pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_addr, inst_fault,
    output inst_ready,
    output jump_en, jump_addr,
    input  pc
  );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Instruction-fetch unit: owns the PC, issues one memory request at a time and
// buffers the returned instruction for decode, handling redirects mid-fetch.
module ysyx_23060332_ifu #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  ysyx_23060332_ifu_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic            kill_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] inst_q;
  logic [XLEN-1:0] inst_addr_q;
  logic            inst_fault_q;

  logic [XLEN-1:0] pc_d;
  logic            req_fire;
  logic            jump_mis;

  assign pc_d     = pc_q + XLEN'(PC_STEP);
  assign req_fire = (state_q == S_REQ) && bus.imem_req_ready;
  assign jump_mis = bus.jump_addr[1:0] != 2'b00;

  // kill_q marks an in-flight request whose response must be discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      kill_q       <= 1'b0;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_addr_q  <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      if (bus.jump_en) pc_q <= bus.jump_addr;
      case (state_q)
        S_REQ: begin
          if (bus.jump_en) begin
            if (req_fire) kill_q <= 1'b1;
            if (jump_mis) begin
              inst_q       <= '0;
              inst_addr_q  <= bus.jump_addr;
              inst_fault_q <= 1'b1;
              state_q      <= S_HOLD;
            end else if (req_fire) begin
              state_q <= S_WAIT;
            end
          end else if (req_fire) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.jump_en) begin
            kill_q <= !bus.imem_rsp_valid;
            if (jump_mis) begin
              inst_q       <= '0;
              inst_addr_q  <= bus.jump_addr;
              inst_fault_q <= 1'b1;
              state_q      <= S_HOLD;
            end else if (bus.imem_rsp_valid) begin
              state_q <= S_REQ;
            end
          end else if (bus.imem_rsp_valid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q       <= bus.imem_rsp_data;
              inst_addr_q  <= pc_q;
              inst_fault_q <= bus.imem_rsp_err;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A redirect drops the buffered entry even if decode takes it this cycle.
          if (bus.jump_en) begin
            if (jump_mis) begin
              inst_q       <= '0;
              inst_addr_q  <= bus.jump_addr;
              inst_fault_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
            end
          end else if (bus.inst_ready) begin
            pc_q    <= pc_d;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_addr      = inst_addr_q;
  assign bus.inst_fault     = inst_fault_q;
  assign bus.pc             = pc_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Bench for ysyx_23060332_ifu: directed scenarios plus a randomized run checked
// against a delivery-level model of the expected instruction stream.
module tb_ysyx_23060332_ifu;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060332_ifu_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();
  ysyx_23060332_ifu_if #(.XLEN(XLEN), .ILEN(ILEN)) wbus ();

  ysyx_23060332_ifu #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(32'h8000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ysyx_23060332_ifu #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(rst), .bus(wbus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // memory model state
  bit          busy     = 1'b0;
  int          cnt      = 0;
  logic [31:0] maddr    = '0;
  int          mem_lat  = 1;
  bit          rdy_rand = 1'b0;
  bit          spur     = 1'b0;
  logic [31:0] fault_addr = '0;

  // reference model: address of the next instruction to deliver
  logic [31:0] exp_pc  = 32'h8000_0000;
  bit          exp_mis = 1'b0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic memerr(input logic [31:0] a);
    return (fault_addr != 32'h0) && (a == fault_addr);
  endfunction

  task automatic tick();
    logic        fire, deliv, j, rsp_real, r;
    logic [31:0] ja, ra;
    rsp_real = busy && (cnt == 0);
    bus.imem_rsp_valid = rsp_real;
    bus.imem_rsp_data  = memdata(maddr);
    bus.imem_rsp_err   = memerr(maddr);
    if (!busy && spur && $urandom_range(0, 3) == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
      bus.imem_rsp_err   = 1'($urandom_range(0, 1));
    end
    bus.imem_req_ready = !busy && (!rdy_rand || $urandom_range(0, 1) == 1);
    fire  = bus.imem_req_valid && bus.imem_req_ready;
    ra    = bus.imem_req_addr;
    deliv = bus.inst_valid && bus.inst_ready;
    j     = bus.jump_en;
    ja    = bus.jump_addr;
    r     = rst;
    @(posedge clk);
    #1;
    if (r) begin
      busy    = 1'b0;
      exp_pc  = 32'h8000_0000;
      exp_mis = 1'b0;
    end else begin
      if (rsp_real) busy = 1'b0;
      else if (busy) cnt--;
      if (fire) begin
        busy  = 1'b1;
        cnt   = mem_lat - 1;
        maddr = ra;
      end
      if (j) begin
        exp_pc  = ja;
        exp_mis = (ja[1:0] != 2'b00);
      end else if (deliv) begin
        exp_pc  = exp_pc + 32'd4;
        exp_mis = 1'b0;
      end
    end
  endtask

  task automatic jump_to(input logic [31:0] a);
    bus.jump_en   = 1'b1;
    bus.jump_addr = a;
    tick();
    bus.jump_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.imem_req_valid !== 1'b1) $display("FAIL reset_req_valid got %b want 1", bus.imem_req_valid); else n_pass++;
    n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b want 0", bus.inst_valid); else n_pass++;
    n_checks++; if (bus.pc !== 32'h8000_0000) $display("FAIL reset_pc got %h want 80000000", bus.pc); else n_pass++;
    n_checks++; if (bus.inst !== 32'h0) $display("FAIL reset_inst got %h want 0", bus.inst); else n_pass++;
    n_checks++; if (bus.inst_addr !== 32'h0) $display("FAIL reset_inst_addr got %h want 0", bus.inst_addr); else n_pass++;
    n_checks++; if (bus.inst_fault !== 1'b0) $display("FAIL reset_inst_fault got %b want 0", bus.inst_fault); else n_pass++;
    n_checks++; if (wbus.pc !== 32'hFFFF_FFFC) $display("FAIL reset_wrap_pc got %h want fffffffc", wbus.pc); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_straight();
    int          k = 0;
    int          dcyc [3];
    logic [31:0] daddr[3];
    logic [31:0] dinst[3];
    bus.inst_ready = 1'b1;
    mem_lat = 1;
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000)
      $display("FAIL first_req got valid=%b addr=%h want valid=1 addr=80000000", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      if (bus.inst_valid && k < 3) begin
        dcyc[k] = c; daddr[k] = bus.inst_addr; dinst[k] = bus.inst; k++;
      end
      tick();
    end
    n_checks++; if (k !== 3) $display("FAIL straight_count got %0d want 3", k); else n_pass++;
    for (int i = 0; i < k; i++) begin
      n_checks++; if (dcyc[i] !== 2 + 3 * i) $display("FAIL straight_cycle[%0d] got %0d want %0d", i, dcyc[i], 2 + 3 * i); else n_pass++;
      n_checks++; if (daddr[i] !== 32'h8000_0000 + 32'(4 * i)) $display("FAIL straight_addr[%0d] got %h want %h", i, daddr[i], 32'h8000_0000 + 32'(4 * i)); else n_pass++;
      n_checks++; if (dinst[i] !== memdata(32'h8000_0000 + 32'(4 * i))) $display("FAIL straight_inst[%0d] got %h want %h", i, dinst[i], memdata(32'h8000_0000 + 32'(4 * i))); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    n_checks++; if (wbus.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req0 got %h want fffffffc", wbus.imem_req_addr); else n_pass++;
    wbus.imem_req_ready = 1'b1;
    tick();
    wbus.imem_req_ready = 1'b0;
    wbus.imem_rsp_valid = 1'b1;
    wbus.imem_rsp_data  = 32'hCAFE_0001;
    tick();
    wbus.imem_rsp_valid = 1'b0;
    n_checks++; if (wbus.inst_valid !== 1'b1 || wbus.inst_addr !== 32'hFFFF_FFFC || wbus.inst !== 32'hCAFE_0001)
      $display("FAIL wrap_deliver got v=%b addr=%h inst=%h want v=1 addr=fffffffc inst=cafe0001", wbus.inst_valid, wbus.inst_addr, wbus.inst); else n_pass++;
    wbus.inst_ready = 1'b1;
    tick();
    wbus.inst_ready = 1'b0;
    n_checks++; if (wbus.pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", wbus.pc); else n_pass++;
    n_checks++; if (wbus.imem_req_valid !== 1'b1 || wbus.imem_req_addr !== 32'h0)
      $display("FAIL wrap_req1 got valid=%b addr=%h want valid=1 addr=0", wbus.imem_req_valid, wbus.imem_req_addr); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] s_addr, s_inst, s_pc;
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20 && !bus.inst_valid; k++) tick();
    n_checks++; if (bus.inst_valid !== 1'b1) $display("FAIL bp_timeout got inst_valid=%b want 1", bus.inst_valid); else n_pass++;
    s_addr = bus.inst_addr; s_inst = bus.inst; s_pc = bus.pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (bus.inst_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_addr !== s_addr || bus.inst !== s_inst || bus.pc !== s_pc)
        $display("FAIL bp_hold[%0d] got v=%b req=%b addr=%h inst=%h pc=%h want v=1 req=0 addr=%h inst=%h pc=%h",
                 k, bus.inst_valid, bus.imem_req_valid, bus.inst_addr, bus.inst, bus.pc, s_addr, s_inst, s_pc);
      else n_pass++;
    end
    bus.inst_ready = 1'b1;
    tick();
    n_checks++; if (bus.pc !== s_pc + 32'd4) $display("FAIL bp_release_pc got %h want %h", bus.pc, s_pc + 32'd4); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    logic [31:0] first_req = '0;
    bit          seen = 1'b0;
    mem_lat = 3;
    for (int k = 0; k < 20 && !bus.imem_req_valid; k++) tick();
    tick();
    jump_to(32'h8000_0100);
    for (int k = 0; k < 30 && !bus.inst_valid; k++) begin
      if (bus.imem_req_valid && !seen) begin first_req = bus.imem_req_addr; seen = 1'b1; end
      tick();
    end
    n_checks++; if (first_req !== 32'h8000_0100) $display("FAIL rw_req_addr got %h want 80000100", first_req); else n_pass++;
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'h8000_0100 || bus.inst !== memdata(32'h8000_0100))
      $display("FAIL rw_deliver got v=%b addr=%h inst=%h want v=1 addr=80000100 inst=%h", bus.inst_valid, bus.inst_addr, bus.inst, memdata(32'h8000_0100)); else n_pass++;
  endtask

  task automatic test_redirect_hold();
    bit saw14 = 1'b0;
    mem_lat = 1;
    bus.inst_ready = 1'b0;
    jump_to(32'h8000_0010);
    for (int k = 0; k < 20 && !bus.inst_valid; k++) tick();
    n_checks++; if (bus.inst_addr !== 32'h8000_0010) $display("FAIL rh_first got %h want 80000010", bus.inst_addr); else n_pass++;
    bus.inst_ready = 1'b1;
    jump_to(32'h8000_0040);
    for (int k = 0; k < 20 && !bus.inst_valid; k++) begin
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h8000_0014) saw14 = 1'b1;
      tick();
    end
    n_checks++; if (saw14 !== 1'b0) $display("FAIL rh_skip got fetch_0014=%b want 0", saw14); else n_pass++;
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'h8000_0040 || bus.pc !== 32'h8000_0040)
      $display("FAIL rh_target got v=%b addr=%h pc=%h want v=1 addr=80000040 pc=80000040", bus.inst_valid, bus.inst_addr, bus.pc); else n_pass++;
  endtask

  task automatic test_misaligned();
    bit req_seen = 1'b0;
    bus.inst_ready = 1'b0;
    jump_to(32'h8000_0102);
    n_checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_fault !== 1'b1 || bus.inst !== 32'h0 || bus.inst_addr !== 32'h8000_0102 || bus.pc !== 32'h8000_0102)
      $display("FAIL mis_entry got v=%b f=%b inst=%h addr=%h pc=%h want v=1 f=1 inst=0 addr=80000102 pc=80000102",
               bus.inst_valid, bus.inst_fault, bus.inst, bus.inst_addr, bus.pc);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (bus.imem_req_valid) req_seen = 1'b1;
      tick();
    end
    n_checks++; if (req_seen !== 1'b0) $display("FAIL mis_no_req got req=%b want 0", req_seen); else n_pass++;
  endtask

  task automatic test_fault();
    fault_addr = 32'h8000_0200;
    bus.inst_ready = 1'b0;
    jump_to(32'h8000_0200);
    for (int k = 0; k < 20 && !bus.inst_valid; k++) tick();
    n_checks++; if (bus.inst_addr !== 32'h8000_0200 || bus.inst_fault !== 1'b1 || bus.inst !== memdata(32'h8000_0200))
      $display("FAIL fault_entry got addr=%h f=%b inst=%h want addr=80000200 f=1 inst=%h", bus.inst_addr, bus.inst_fault, bus.inst, memdata(32'h8000_0200)); else n_pass++;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20 && !bus.inst_valid; k++) tick();
    n_checks++; if (bus.inst_addr !== 32'h8000_0204 || bus.inst_fault !== 1'b0)
      $display("FAIL fault_next got addr=%h f=%b want addr=80000204 f=0", bus.inst_addr, bus.inst_fault); else n_pass++;
  endtask

  task automatic test_reset_midfetch();
    mem_lat = 4;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 20 && !bus.imem_req_valid; k++) tick();
    tick();
    jump_to(32'h8000_0300);
    mem_lat = 1;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.pc !== 32'h8000_0000 || bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.inst_addr !== 32'h0 || bus.inst_fault !== 1'b0)
      $display("FAIL midrst_state got pc=%h v=%b req=%b addr=%h f=%b want pc=80000000 v=0 req=1 addr=0 f=0",
               bus.pc, bus.inst_valid, bus.imem_req_valid, bus.inst_addr, bus.inst_fault);
    else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'h8000_0000 || bus.inst !== memdata(32'h8000_0000))
      $display("FAIL midrst_first got v=%b addr=%h inst=%h want v=1 addr=80000000 inst=%h", bus.inst_valid, bus.inst_addr, bus.inst, memdata(32'h8000_0000)); else n_pass++;
  endtask

  task automatic test_random();
    int since = 0;
    rdy_rand = 1'b1;
    spur     = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      n_checks++; if (bus.pc !== exp_pc) $display("FAIL rnd_pc c=%0d got %h want %h", c, bus.pc, exp_pc); else n_pass++;
      if (bus.imem_req_valid) begin
        n_checks++;
        if (bus.imem_req_addr !== exp_pc || bus.inst_valid !== 1'b0)
          $display("FAIL rnd_req c=%0d got addr=%h v=%b want addr=%h v=0", c, bus.imem_req_addr, bus.inst_valid, exp_pc);
        else n_pass++;
      end
      if (bus.inst_valid) begin
        since = 0;
        n_checks++;
        if (bus.inst_addr !== exp_pc || bus.inst !== (exp_mis ? 32'h0 : memdata(exp_pc)) || bus.inst_fault !== (exp_mis ? 1'b1 : memerr(exp_pc)))
          $display("FAIL rnd_inst c=%0d got addr=%h inst=%h f=%b want addr=%h inst=%h f=%b", c, bus.inst_addr, bus.inst, bus.inst_fault,
                   exp_pc, exp_mis ? 32'h0 : memdata(exp_pc), exp_mis ? 1'b1 : memerr(exp_pc));
        else n_pass++;
      end else begin
        since++;
        if (since > 100) begin
          n_checks++;
          $display("FAIL rnd_progress c=%0d got %0d idle cycles want <=100", c, since);
          break;
        end
      end
      bus.inst_ready = ($urandom_range(0, 2) != 0);
      mem_lat        = $urandom_range(1, 4);
      bus.jump_en    = ($urandom_range(0, 9) == 0);
      bus.jump_addr  = 32'h8000_0000 + 32'($urandom_range(0, 255) * 4) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      tick();
    end
    bus.jump_en = 1'b0;
  endtask

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.imem_rsp_err    = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.jump_en         = 1'b0;
    bus.jump_addr       = '0;
    wbus.imem_req_ready = 1'b0;
    wbus.imem_rsp_valid = 1'b0;
    wbus.imem_rsp_data  = '0;
    wbus.imem_rsp_err   = 1'b0;
    wbus.inst_ready     = 1'b0;
    wbus.jump_en        = 1'b0;
    wbus.jump_addr      = '0;
    test_reset();
    test_straight();
    test_wrap();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_misaligned();
    test_fault();
    test_reset_midfetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_23060332_ifu.md
# ysyx_23060332_ifu

Parametrised instruction-fetch unit for the multi-cycle core. It replaces the free-running PC with a valid/ready fetch engine that owns the PC, issues one request at a time to instruction memory, and buffers the returned instruction for the decoder. It also handles redirects from the execute stage, including redirects that land while a fetch is still in flight. It sits between the instruction-memory port and the decode stage in the core top.

## Interface

Parameters:

- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- RESET_PC, 32'h8000_0000, PC value after reset
- PC_STEP, 4, sequential PC increment

Ports:

- clk  in  1  core clock; one clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response valid (one-cycle pulse, always accepted)
- imem_rsp_data  in  ILEN  fetched instruction
- imem_rsp_err  in  1  access fault on this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  ILEN  buffered instruction
- inst_addr  out  XLEN  address of buffered instruction
- inst_fault  out  1  buffered entry is a fetch/misalign fault
- jump_en  in  1  redirect from execute
- jump_addr  in  XLEN  redirect target
- pc  out  XLEN  current fetch PC register

## Operation

- The FSM has three states.
  - REQ: imem_req_valid=1, addr=pc. On imem_req_ready, go to WAIT.
  - WAIT: wait for imem_rsp_valid. On the response:
    - If kill=1: drop the response, clear kill, go to REQ.
    - Otherwise: latch inst=rsp_data, inst_addr=pc, inst_fault=rsp_err, and go to HOLD.
  - HOLD: inst_valid=1. On inst_ready: pc <= pc+PC_STEP (mod 2^XLEN) and go to REQ.
- Redirect (jump_en=1) always wins over the sequential update: pc <= jump_addr. Behaviour per state:
  - REQ without a same-cycle handshake: stay in REQ with the new address.
  - REQ with a same-cycle handshake: go to WAIT with kill=1.
  - WAIT without a same-cycle response: kill <= 1.
  - WAIT with a same-cycle response: drop the response and go to REQ.
  - HOLD: the buffer is invalidated, regardless of inst_ready, and the FSM goes to REQ.
- Misaligned redirect: if jump_addr[1:0]!=0, pc <= jump_addr and the FSM enters HOLD directly with no memory request.
  - Buffer contents: inst=0, inst_addr=jump_addr, inst_fault=1.
  - Any outstanding response is still dropped via kill.
- imem_rsp_valid outside WAIT is ignored.
- Output buffer and control outputs are registered; none depends combinationally on inst_ready.
- No addressable instruction is ever delivered twice or skipped except by redirect.

## Timing

- Reset values:
  - pc=RESET_PC, state=REQ, kill=0.
  - inst_valid=0, inst=0, inst_addr=0, inst_fault=0.
  - imem_req_valid=1 from the first cycle after rst deasserts. It is also 1 during reset, since state=REQ, so the memory must be held in reset alongside the IFU.
- Latency, zero-wait memory (req accepted in cycle N, response in N+1): inst_valid=1 in cycle N+2.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD). With inst_ready tied high, HOLD lasts 1 cycle.
- Handshake rules:
  - imem_req_valid/addr stay stable until accepted, except when a redirect changes the address.
  - inst/inst_addr/inst_fault stay stable while inst_valid=1 and not consumed.
- Simultaneous jump_en with inst_ready in HOLD: the instruction counts as consumed and pc=jump_addr.
- rst mid-fetch: all state returns to reset values next cycle; a kill pending at reset is cleared.
- PC wrap: pc=2^XLEN-PC_STEP followed by a sequential step gives pc=0.

## Test plan

- Reset + straight line: RESET_PC=0x8000_0000, zero-wait memory returning addr-tagged data, inst_ready=1 → inst_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; first inst_valid 2 cycles after first request handshake.
- Backpressure: hold inst_ready=0 for 5 cycles in HOLD → inst/inst_addr unchanged, no new imem request, pc unchanged; on release pc advances by exactly 4.
- Redirect in WAIT: memory latency 3, jump_en to 0x8000_0100 one cycle after request accept → stale response dropped, next request addr 0x8000_0100, first delivered inst_addr=0x8000_0100.
- Redirect with inst_ready in HOLD at inst_addr 0x8000_0010, jump_addr=0x8000_0040 → next inst_addr=0x8000_0040; 0x8000_0014 never fetched.
- Misaligned redirect jump_addr=0x8000_0102 → no imem request, inst_valid=1 with inst_fault=1, inst=0, inst_addr=0x8000_0102.
- Fault and wrap: rsp_err=1 → inst_fault=1 delivered. Separately, RESET_PC=0xFFFF_FFFC → second fetch addr 0x0000_0000.
